// File: rtl/channel_cfg_seq.sv
// Channel configuration sequencer: holds a 4-case coefficient table plus sigma and
// sweeps cases 0..last_case through LOAD/SETTLE/RUN, driving the channel enable.
module channel_cfg_seq #(
  parameter int NB_COEF    = 14,
  parameter int NB_SIG     = 10,
  parameter int NB_RUN     = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                      CLK100MHZ,
  input  logic                      ck_rst,
  input  logic                      i_wr_en,
  input  logic [4:0]                i_wr_addr,
  input  logic signed [NB_COEF-1:0] i_wr_data,
  input  logic                      i_sigma_wr,
  input  logic [NB_SIG-1:0]         i_sigma,
  input  logic [1:0]                i_last_case,
  input  logic [NB_RUN-1:0]         i_run_len,
  input  logic                      i_start,
  input  logic                      i_abort,
  output logic signed [NB_COEF-1:0] o_coefA,
  output logic signed [NB_COEF-1:0] o_coefB,
  output logic signed [NB_COEF-1:0] o_coefC,
  output logic signed [NB_COEF-1:0] o_coefD,
  output logic signed [NB_COEF-1:0] o_coefE,
  output logic signed [NB_COEF-1:0] o_coefF,
  output logic signed [NB_COEF-1:0] o_coefG,
  output logic signed [NB_COEF-1:0] o_coefH,
  output logic [NB_SIG-1:0]         o_sigma,
  output logic                      o_enable,
  output logic [1:0]                o_case_idx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_wr_err
);

  localparam int NB_CLG = $clog2(SETTLE_CYC + 1);
  localparam int NB_CNT = (NB_RUN > NB_CLG) ? NB_RUN : NB_CLG;
  localparam logic [NB_CNT-1:0] SETTLE_LAST = NB_CNT'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                    state_r, state_s;
  logic [NB_CNT-1:0]         cnt_r, cnt_s;
  logic [NB_CNT-1:0]         run_last_s;
  logic [NB_RUN-1:0]         run_len_r, run_len_s;
  logic [1:0]                last_r, last_s;
  logic [1:0]                case_s;
  logic                      load_s;
  logic signed [NB_COEF-1:0] table_r [32];
  logic [NB_SIG-1:0]         sigma_r;

  // Next-state, counter and case-index logic; abort overrides every state.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    run_len_s  = run_len_r;
    last_s     = last_r;
    case_s     = o_case_idx;
    load_s     = 1'b0;
    run_last_s = NB_CNT'(run_len_r) - NB_CNT'(1);
    if (i_abort) begin
      state_s = S_IDLE;
      cnt_s   = '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_start && (i_run_len != '0)) begin
            state_s   = S_LOAD;
            case_s    = 2'd0;
            run_len_s = i_run_len;
            last_s    = i_last_case;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LOAD: begin
          state_s = S_SETTLE;
          cnt_s   = '0;
          load_s  = 1'b1;
        end
        S_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_s = S_RUN;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + NB_CNT'(1);
          end
        end
        S_RUN: begin
          if (cnt_r == run_last_s) begin
            cnt_s = '0;
            if (o_case_idx < last_r) begin
              case_s  = o_case_idx + 2'd1;
              state_s = S_LOAD;
            end else begin
              state_s = S_DONE;
            end
          end else begin
            cnt_s = cnt_r + NB_CNT'(1);
          end
        end
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      run_len_r  <= '0;
      last_r     <= 2'd0;
      o_case_idx <= 2'd0;
      o_busy     <= 1'b0;
      o_enable   <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      run_len_r  <= run_len_s;
      last_r     <= last_s;
      o_case_idx <= case_s;
      o_busy     <= (state_s == S_LOAD) || (state_s == S_SETTLE) || (state_s == S_RUN);
      o_enable   <= (state_s == S_RUN);
      o_done     <= (state_s == S_DONE);
    end
  end

  // Coefficient table and sigma storage; writes are rejected while a sweep runs.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      for (int i = 0; i < 32; i++) table_r[i] <= '0;
      sigma_r  <= '0;
      o_wr_err <= 1'b0;
    end else begin
      o_wr_err <= (i_wr_en || i_sigma_wr) && o_busy;
      if (i_wr_en && !o_busy) table_r[i_wr_addr] <= i_wr_data;
      if (i_sigma_wr && !o_busy) sigma_r <= i_sigma;
    end
  end

  // Channel parameter outputs, captured from the table during LOAD and held otherwise.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst) begin
      o_coefA <= '0; o_coefB <= '0; o_coefC <= '0; o_coefD <= '0;
      o_coefE <= '0; o_coefF <= '0; o_coefG <= '0; o_coefH <= '0;
      o_sigma <= '0;
    end else if (load_s) begin
      o_coefA <= table_r[{o_case_idx, 3'd0}];
      o_coefB <= table_r[{o_case_idx, 3'd1}];
      o_coefC <= table_r[{o_case_idx, 3'd2}];
      o_coefD <= table_r[{o_case_idx, 3'd3}];
      o_coefE <= table_r[{o_case_idx, 3'd4}];
      o_coefF <= table_r[{o_case_idx, 3'd5}];
      o_coefG <= table_r[{o_case_idx, 3'd6}];
      o_coefH <= table_r[{o_case_idx, 3'd7}];
      o_sigma <= sigma_r;
    end
  end

endmodule

// File: tb/tb_channel_cfg_seq.sv
// Scoreboard bench for channel_cfg_seq: expected runs, done pulses and write errors
// are queued by the stimulus and checked by a negedge monitor.
module tb_channel_cfg_seq;

  logic        CLK100MHZ = 1'b0;
  logic        ck_rst, i_wr_en, i_sigma_wr, i_start, i_abort;
  logic [4:0]  i_wr_addr;
  logic [13:0] i_wr_data;
  logic [9:0]  i_sigma;
  logic [1:0]  i_last_case;
  logic [15:0] i_run_len;
  logic [13:0] o_coefA, o_coefB, o_coefC, o_coefD, o_coefE, o_coefF, o_coefG, o_coefH;
  logic [9:0]  o_sigma;
  logic        o_enable, o_busy, o_done, o_wr_err;
  logic [1:0]  o_case_idx;

  typedef struct {
    logic [1:0]  idx;
    logic [13:0] a, b, c, h;
    logic [9:0]  sig;
    int          len;
  } run_t;

  run_t q_run[$];
  int   q_done[$];
  int   q_werr[$];
  int   n_pass = 0;
  int   n_total = 0;

  channel_cfg_seq dut (
    .CLK100MHZ(CLK100MHZ), .ck_rst(ck_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_sigma_wr(i_sigma_wr), .i_sigma(i_sigma),
    .i_last_case(i_last_case), .i_run_len(i_run_len), .i_start(i_start), .i_abort(i_abort),
    .o_coefA(o_coefA), .o_coefB(o_coefB), .o_coefC(o_coefC), .o_coefD(o_coefD),
    .o_coefE(o_coefE), .o_coefF(o_coefF), .o_coefG(o_coefG), .o_coefH(o_coefH),
    .o_sigma(o_sigma), .o_enable(o_enable), .o_case_idx(o_case_idx), .o_busy(o_busy),
    .o_done(o_done), .o_wr_err(o_wr_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [13:0] data);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    cyc();
    i_wr_en = 1'b0;
  endtask

  task automatic sig_wr(input logic [9:0] s);
    i_sigma_wr = 1'b1; i_sigma = s;
    cyc();
    i_sigma_wr = 1'b0;
  endtask

  task automatic start(input logic [1:0] last, input logic [15:0] len);
    i_last_case = last; i_run_len = len; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic push_run(input logic [1:0] idx, input logic [13:0] a, input logic [13:0] b,
                          input logic [13:0] c, input logic [13:0] h, input logic [9:0] s,
                          input int len);
    run_t r;
    r.idx = idx; r.a = a; r.b = b; r.c = c; r.h = h; r.sig = s; r.len = len;
    q_run.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 200) begin cyc(); n++; end
    if (n >= 200) chk({name, "_timeout"}, 32'd1, 32'd0);
    cyc(); cyc();
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!o_enable && n < 50) begin cyc(); n++; end
    if (n >= 50) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Monitor: checks each enable window, done pulse and write-error pulse against the queues.
  run_t cur;
  int   en_cnt = 0, gap_cnt = 0;
  logic prev_en = 1'b0;
  always @(negedge CLK100MHZ) begin
    if (!ck_rst) begin
      en_cnt = 0; gap_cnt = 0; prev_en = 1'b0;
    end else begin
      if (o_enable && !prev_en) begin
        if (q_run.size() == 0) begin
          chk("unexpected_run", 32'd1, 32'd0);
          cur.len = -1;
        end else begin
          cur = q_run.pop_front();
          chk("run_case_idx", 32'(o_case_idx), 32'(cur.idx));
          chk("run_coefA", 32'(o_coefA), 32'(cur.a));
          chk("run_coefB", 32'(o_coefB), 32'(cur.b));
          chk("run_coefC", 32'(o_coefC), 32'(cur.c));
          chk("run_coefH", 32'(o_coefH), 32'(cur.h));
          chk("run_sigma", 32'(o_sigma), 32'(cur.sig));
          chk("settle_gap", 32'(gap_cnt), 32'd9);
        end
        gap_cnt = 0;
      end
      if (o_enable) en_cnt++;
      else if (o_busy) gap_cnt++;
      else gap_cnt = 0;
      if (!o_enable && prev_en) begin
        if (cur.len >= 0) chk("run_len", 32'(en_cnt), 32'(cur.len));
        en_cnt = 0;
      end
      if (o_done) begin
        if (q_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin void'(q_done.pop_front()); chk("done_idle", 32'(o_busy | o_enable), 32'd0); end
      end
      if (o_wr_err) begin
        if (q_werr.size() == 0) chk("unexpected_wr_err", 32'd1, 32'd0);
        else begin void'(q_werr.pop_front()); chk("wr_err_busy", 32'(o_busy), 32'd1); end
      end
      prev_en = o_enable;
    end
  end

  initial begin
    ck_rst = 1'b0; i_wr_en = 1'b0; i_wr_addr = 5'd0; i_wr_data = 14'd0; i_sigma_wr = 1'b0;
    i_sigma = 10'd0; i_last_case = 2'd0; i_run_len = 16'd0; i_start = 1'b0; i_abort = 1'b0;
    cyc(); cyc();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_enable", 32'(o_enable), 32'd0);
    chk("rst_done_err", 32'({o_done, o_wr_err}), 32'd0);
    chk("rst_coefA", 32'(o_coefA), 32'd0);
    chk("rst_sigma_idx", 32'({o_sigma, o_case_idx}), 32'd0);
    ck_rst = 1'b1;
    cyc();

    // Single case sweep
    wr(5'd0, 14'h1000); wr(5'd1, 14'h1000); sig_wr(10'h039);
    push_run(2'd0, 14'h1000, 14'h1000, 14'h0000, 14'h0000, 10'h039, 3);
    q_done.push_back(1);
    start(2'd0, 16'd3);
    chk("load_busy", 32'(o_busy), 32'd1);
    chk("load_enable", 32'(o_enable), 32'd0);
    wait_idle("sweep1");

    // Two case sweep with a negative coefficient in case 1
    wr(5'd8, 14'h0FE4); wr(5'd9, 14'h0FE4); wr(5'd10, 14'h01E1); wr(5'd11, 14'h01E1);
    wr(5'd15, 14'h2001);
    push_run(2'd0, 14'h1000, 14'h1000, 14'h0000, 14'h0000, 10'h039, 2);
    push_run(2'd1, 14'h0FE4, 14'h0FE4, 14'h01E1, 14'h2001, 10'h039, 2);
    q_done.push_back(1);
    start(2'd1, 16'd2);
    wait_idle("sweep2");
    chk("idle_case_hold", 32'(o_case_idx), 32'd1);

    // Writes and a second start during RUN are rejected
    push_run(2'd0, 14'h1000, 14'h1000, 14'h0000, 14'h0000, 10'h039, 4);
    push_run(2'd1, 14'h0FE4, 14'h0FE4, 14'h01E1, 14'h2001, 10'h039, 4);
    q_done.push_back(1);
    start(2'd1, 16'd4);
    wait_en("werr_en");
    q_werr.push_back(1); wr(5'd0, 14'h3FFF);
    q_werr.push_back(1); sig_wr(10'h3FF);
    i_run_len = 16'd9; i_start = 1'b1; cyc(); i_start = 1'b0;
    wait_idle("sweep3");
    push_run(2'd0, 14'h1000, 14'h1000, 14'h0000, 14'h0000, 10'h039, 1);
    push_run(2'd1, 14'h0FE4, 14'h0FE4, 14'h01E1, 14'h2001, 10'h039, 1);
    q_done.push_back(1);
    start(2'd1, 16'd1);
    wait_idle("sweep4");

    // Abort in the second RUN cycle
    push_run(2'd0, 14'h1000, 14'h1000, 14'h0000, 14'h0000, 10'h039, 2);
    start(2'd0, 16'd5);
    wait_en("abort_en");
    cyc();
    i_abort = 1'b1; cyc(); i_abort = 1'b0;
    chk("abort_enable", 32'(o_enable), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    cyc(); cyc();

    // Zero run length and abort-with-start are ignored
    start(2'd0, 16'd0);
    chk("zero_len_busy", 32'(o_busy), 32'd0);
    cyc();
    chk("zero_len_busy2", 32'(o_busy), 32'd0);
    i_abort = 1'b1; i_start = 1'b1; i_run_len = 16'd3; cyc();
    i_abort = 1'b0; i_start = 1'b0;
    chk("abort_start_busy", 32'(o_busy), 32'd0);
    cyc();

    // Reset in SETTLE clears outputs and table
    start(2'd1, 16'd3);
    cyc(); cyc(); cyc();
    ck_rst = 1'b0; cyc();
    chk("midrst_busy_en", 32'({o_busy, o_enable, o_done}), 32'd0);
    chk("midrst_coefA", 32'(o_coefA), 32'd0);
    chk("midrst_sigma", 32'(o_sigma), 32'd0);
    chk("midrst_case", 32'(o_case_idx), 32'd0);
    ck_rst = 1'b1; cyc();
    push_run(2'd0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 10'h000, 1);
    push_run(2'd1, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 10'h000, 1);
    q_done.push_back(1);
    start(2'd1, 16'd1);
    wait_idle("sweep5");

    cyc(); cyc();
    chk("q_run_empty", 32'(q_run.size()), 32'd0);
    chk("q_done_empty", 32'(q_done.size()), 32'd0);
    chk("q_werr_empty", 32'(q_werr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
